pipe_cla_addsub: RTL and testbench

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

---
 rtl/pipe_cla_addsub.sv | 152 +++++++++++++++
 tb/tb_pipe_cla_addsub.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead add/sub: STAGES cycles of latency, one beat per cycle, and the whole pipe stalls when the output is held.
// Define PIPE_CLA_SAT_EN to saturate the result on signed overflow. Without it the result wraps modulo 2^WIDTH.
module pipe_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  logic adv;

  assign in_ready = ~out_valid | out_ready;
  assign adv      = in_ready;

  // Two-level lookahead: the carry into each 4-bit group is a flat sum of products.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic c0);
    logic [SW-1:0] g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          t;
    g  = x & y;
    p  = x ^ y;
    c  = '0;
    gc = '0;
    gg = '0;
    gp = '0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      for (int i = 0; i < 4; i++) begin
        t = g[4*j+i];
        for (int m = i + 1; m < 4; m++) t = t & p[4*j+m];
        gg[j] = gg[j] | t;
      end
    end
    for (int j = 0; j <= NG; j++) begin
      t = c0;
      for (int m = 0; m < j; m++) t = t & gp[m];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      for (int bb = 0; bb < 4; bb++) begin
        t = gc[j];
        for (int m = 0; m < bb; m++) t = t & p[4*j+m];
        c[4*j+bb] = t;
        for (int i = 0; i < bb; i++) begin
          t = g[4*j+i];
          for (int m = i + 1; m < bb; m++) t = t & p[4*j+m];
          c[4*j+bb] = c[4*j+bb] | t;
        end
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * SW;
    localparam int HI = WIDTH - LO;

    logic [HI-1:0]    xa, xb;
    logic             xc, xv;
    logic [SW-1:0]    sl;
    logic             co;
    logic [LO+SW-1:0] done;

    if (k == 0) begin : src
      assign xa   = a;
      assign xb   = sub ? ~b : b;
      assign xc   = sub | cin;
      assign xv   = in_valid;
      assign done = sl;
    end else begin : src
      assign xa   = stg[k-1].rg.ra;
      assign xb   = stg[k-1].rg.rb;
      assign xc   = stg[k-1].rg.rc;
      assign xv   = stg[k-1].rg.rv;
      assign done = {sl, stg[k-1].rg.rs};
    end

    assign {co, sl} = slice_add(xa[SW-1:0], xb[SW-1:0], xc);

    if (k < STAGES - 1) begin : rg
      // Unprocessed upper operand bits travel forward with the finished low result bits.
      logic [HI-SW-1:0] ra, rb;
      logic [LO+SW-1:0] rs;
      logic             rc, rv;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rv <= 1'b0;
        else if (adv) rv <= xv;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          ra <= xa[HI-1:SW];
          rb <= xb[HI-1:SW];
          rs <= done;
          rc <= co;
        end
      end
    end else begin : fin
      logic [WIDTH-1:0] res;
      logic             sv;

      always_comb begin
        sv  = (xa[HI-1] == xb[HI-1]) && (done[WIDTH-1] != xa[HI-1]);
        res = done;
`ifdef PIPE_CLA_SAT_EN
        if (sv) res = xa[HI-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          result    <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (adv) begin
          out_valid <= xv;
          result    <= res;
          cout      <= co;
          ovf       <= sv;
          zero      <= (res == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Scoreboarded bench for pipe_cla_addsub (WIDTH=32, STAGES=2) against an arithmetic reference model.
module tb_pipe_cla_addsub;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic             cout, ovf, zero;

  pipe_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                 input logic ci);
    logic [32:0] full;
    logic [31:0] yb;
    exp_t        e;
    yb   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yb} + {32'b0, (s ? 1'b1 : ci)};
    e.r  = full[31:0];
    e.co = full[32];
    e.ov = (x[31] == yb[31]) && (e.r[31] != x[31]);
`ifdef PIPE_CLA_SAT_EN
    if (e.ov) e.r = x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
    e.z = (e.r == 32'h0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hffff_ffff;
      2: return 32'h7fff_ffff;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Expected values enter the scoreboard at the moment a beat is accepted.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) sb.push_back(model(a, b, sub, cin));
  end

  logic        stall_prev = 1'b0;
  logic [35:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_hold", {out_valid, result, cout, ovf, zero}, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got result %0h with no beat outstanding", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.r);
          chk("cout", cout, e.co);
          chk("ovf", ovf, e.ov);
          chk("zero", zero, e.z);
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_valid, result, cout, ovf, zero};
      if (stall_prev) chk("stall_in_ready", in_ready, 1'b0);
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
    int n = 0;
    a = x; b = y; sub = s; cin = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic c, input logic [31:0] er,
                          input logic eco, input logic eov, input logic ez);
    int n = 0;
    a = x; b = y; sub = s; cin = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({name, "_latency"}, n, STAGES);
    chk({name, "_result"}, result, er);
    chk({name, "_cout"}, cout, eco);
    chk({name, "_ovf"}, ovf, eov);
    chk({name, "_zero"}, zero, ez);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("carry_wrap", 32'hffff_ffff, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
`ifdef PIPE_CLA_SAT_EN
    directed("pos_ovf", 32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0, 32'h7fff_ffff, 1'b0, 1'b1, 1'b0);
`else
    directed("pos_ovf", 32'h7fff_ffff, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif
    directed("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hffff_fffe, 1'b0, 1'b0, 1'b0);
    directed("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Four back-to-back beats with the consumer stalling for three cycles.
    fork
      begin
        send(32'h0000_000f, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0fff_ffff, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        send(32'hdead_beef, 32'h1111_1111, 1'b0, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    // Reset with two beats in flight: both must vanish.
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_cout", cout, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    repeat (10) @(negedge clk);
    chk("post_rst_no_stale", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
